// File: rtl/jailbreak_hiscore_if.sv
// Bridge-side bus between the core top-level leaf decode and the high-score store.
interface jailbreak_hiscore_if;
    logic [31:0] bridge_addr;
    logic        bridge_wr;
    logic [31:0] bridge_wr_data;
    logic        bridge_rd;
    logic        hs_selected;
    logic [31:0] hs_rd_data;

    modport master (
        output bridge_addr, bridge_wr, bridge_wr_data, bridge_rd,
        input  hs_selected, hs_rd_data
    );

    modport slave (
        input  bridge_addr, bridge_wr, bridge_wr_data, bridge_rd,
        output hs_selected, hs_rd_data
    );
endinterface

// File: rtl/jailbreak_hiscore.sv
// High-score shadow store: snoops CPU writes, serves the APF bridge window,
// and DMA-restores the table into work RAM after the host load completes.
module jailbreak_hiscore #(
    parameter logic [31:0]           HS_BASE_ADDR = 32'h2000_0000,
    parameter int unsigned           HS_BYTES     = 64,
    parameter int unsigned           CPU_ADDR_W   = 16,
    parameter logic [CPU_ADDR_W-1:0] CPU_HS_START = 16'h5C80
) (
    input  logic                  clk_74a,
    input  logic                  reset,
    jailbreak_hiscore_if.slave    bus,
    input  logic                  load_done,
    input  logic [CPU_ADDR_W-1:0] cpu_addr,
    input  logic                  cpu_wr,
    input  logic [7:0]            cpu_wr_data,
    output logic                  halt_req,
    input  logic                  halt_ack,
    output logic                  dma_wr,
    output logic [CPU_ADDR_W-1:0] dma_addr,
    output logic [7:0]            dma_data,
    output logic                  hs_dirty,
    input  logic                  hs_dirty_clr
);

    localparam int unsigned BI_W = $clog2(HS_BYTES);
    localparam int unsigned CW   = CPU_ADDR_W + 1;
    localparam logic [32:0]   WIN_LO  = {1'b0, HS_BASE_ADDR};
    localparam logic [32:0]   WIN_HI  = WIN_LO + 33'(HS_BYTES);
    localparam logic [CW-1:0] CPU_LO  = {1'b0, CPU_HS_START};
    localparam logic [CW-1:0] CPU_HI  = CPU_LO + CW'(HS_BYTES);
    localparam logic [BI_W-1:0] LAST  = BI_W'(HS_BYTES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HALT, ST_COPY, ST_DONE} state_t;

    state_t                state, state_nxt;
    logic [BI_W-1:0]       idx, idx_nxt;
    logic                  halt_req_nxt, dma_wr_nxt, pending, pending_nxt;
    logic [CPU_ADDR_W-1:0] dma_addr_nxt;
    logic [7:0]            dma_data_nxt;

    logic [7:0]      shadow [HS_BYTES];
    logic [31:0]     rd_data_q, rd_word_c;
    logic [7:0]      old_byte_c, copy_byte_c;
    logic [BI_W-1:0] br_off, cpu_off;
    logic            in_win, cpu_in, br_wr_c, snoop_c, dirty_set_c;
    logic            unused_c;

    // Window decode at 33 bits so the upper bound cannot wrap.
    assign in_win  = ({1'b0, bus.bridge_addr} >= WIN_LO) && ({1'b0, bus.bridge_addr} < WIN_HI);
    assign cpu_in  = ({1'b0, cpu_addr} >= CPU_LO) && ({1'b0, cpu_addr} < CPU_HI);
    assign br_off  = BI_W'(bus.bridge_addr - HS_BASE_ADDR);
    assign cpu_off = BI_W'(cpu_addr - CPU_HS_START);
    assign br_wr_c = bus.bridge_wr && in_win;
    // A bridge write to the same word takes the whole word; the CPU byte is dropped.
    assign snoop_c = cpu_wr && cpu_in && (state == ST_IDLE) &&
                     !(br_wr_c && ((cpu_off >> 2) == (br_off >> 2)));
    assign dirty_set_c = snoop_c && (cpu_wr_data != old_byte_c);

    assign bus.hs_selected = in_win;
    assign bus.hs_rd_data  = rd_data_q;
    assign unused_c        = bus.bridge_rd;

    // Byte-array read muxes for the bridge word, the snooped byte and the restore byte.
    always_comb begin
        rd_word_c   = '0;
        old_byte_c  = '0;
        copy_byte_c = '0;
        for (int k = 0; k < int'(HS_BYTES); k++) begin
            if ((BI_W'(k) >> 2) == (br_off >> 2)) rd_word_c[8*(3-(k%4)) +: 8] = shadow[k];
            if (BI_W'(k) == cpu_off) old_byte_c = shadow[k];
            if (BI_W'(k) == idx) copy_byte_c = shadow[k];
        end
    end

    always_ff @(posedge clk_74a) begin
        if (reset) begin
            for (int k = 0; k < int'(HS_BYTES); k++) shadow[k] <= '0;
            rd_data_q <= '0;
            hs_dirty  <= 1'b0;
        end else begin
            rd_data_q <= in_win ? rd_word_c : '0;
            for (int k = 0; k < int'(HS_BYTES); k++) begin
                if (br_wr_c && ((BI_W'(k) >> 2) == (br_off >> 2)))
                    shadow[k] <= bus.bridge_wr_data[8*(3-(k%4)) +: 8];
                else if (snoop_c && (BI_W'(k) == cpu_off))
                    shadow[k] <= cpu_wr_data;
            end
            if (dirty_set_c)       hs_dirty <= 1'b1;
            else if (hs_dirty_clr) hs_dirty <= 1'b0;
        end
    end

    always_ff @(posedge clk_74a) begin
        if (reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            halt_req <= 1'b0;
            dma_wr   <= 1'b0;
            dma_addr <= '0;
            dma_data <= '0;
            pending  <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            halt_req <= halt_req_nxt;
            dma_wr   <= dma_wr_nxt;
            dma_addr <= dma_addr_nxt;
            dma_data <= dma_data_nxt;
            pending  <= pending_nxt;
        end
    end

    // Restore sequencer: halt the CPU, stream every shadow byte, release.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        halt_req_nxt = halt_req;
        dma_wr_nxt   = 1'b0;
        dma_addr_nxt = dma_addr;
        dma_data_nxt = dma_data;
        pending_nxt  = pending;
        case (state)
            ST_IDLE: begin
                if (load_done && pending) begin
                    state_nxt    = ST_HALT;
                    halt_req_nxt = 1'b1;
                end
            end
            ST_HALT: begin
                if (halt_ack) begin
                    state_nxt = ST_COPY;
                    idx_nxt   = '0;
                end
            end
            ST_COPY: begin
                dma_wr_nxt   = 1'b1;
                dma_addr_nxt = CPU_HS_START + CPU_ADDR_W'(idx);
                dma_data_nxt = copy_byte_c;
                if (idx == LAST) state_nxt = ST_DONE;
                else             idx_nxt   = idx + BI_W'(1);
            end
            ST_DONE: begin
                halt_req_nxt = 1'b0;
                pending_nxt  = 1'b0;
                state_nxt    = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (br_wr_c) pending_nxt = 1'b1;
    end

endmodule

// File: tb/tb_jailbreak_hiscore.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// byte-array reference model of the high-score store.
module tb_jailbreak_hiscore;

    localparam int unsigned HS_BYTES = 64;
    localparam logic [31:0] BASE     = 32'h2000_0000;
    localparam logic [15:0] CSTART   = 16'h5C80;
    localparam int PH_IDLE = 0, PH_WAIT = 1, PH_COPY = 2, PH_FIN = 3;

    logic        clk_74a = 1'b0;
    logic        reset, load_done, cpu_wr, halt_ack, hs_dirty_clr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wr_data;
    logic        halt_req, dma_wr, hs_dirty;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data;

    always #5 clk_74a = ~clk_74a;

    jailbreak_hiscore_if bus ();

    jailbreak_hiscore dut (
        .clk_74a      (clk_74a),
        .reset        (reset),
        .bus          (bus),
        .load_done    (load_done),
        .cpu_addr     (cpu_addr),
        .cpu_wr       (cpu_wr),
        .cpu_wr_data  (cpu_wr_data),
        .halt_req     (halt_req),
        .halt_ack     (halt_ack),
        .dma_wr       (dma_wr),
        .dma_addr     (dma_addr),
        .dma_data     (dma_data),
        .hs_dirty     (hs_dirty),
        .hs_dirty_clr (hs_dirty_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_74a);
        #1;
    endtask

    // Reference model: shadow table plus a restore job described by phase/position.
    logic [7:0]  m_sh [HS_BYTES];
    bit          m_dirty, m_pending;
    int          m_phase, m_pos;
    logic [31:0] e_rd;
    bit          e_halt, e_dma_wr;
    logic [15:0] e_dma_addr;
    logic [7:0]  e_dma_data;

    function automatic bit m_sel(input logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + longint'(HS_BYTES));
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] a);
        int b;
        b = int'((a - BASE) >> 2) * 4;
        return {m_sh[b], m_sh[b+1], m_sh[b+2], m_sh[b+3]};
    endfunction

    always @(posedge clk_74a) begin : model_b
        logic [31:0] a, nrd;
        bit          snoop_ok, set;
        int          wb, cb;
        a = bus.bridge_addr;
        if (reset) begin
            for (int i = 0; i < int'(HS_BYTES); i++) m_sh[i] = 8'h00;
            m_dirty = 0; m_pending = 0; m_phase = PH_IDLE; m_pos = 0;
            e_rd = '0; e_halt = 0; e_dma_wr = 0; e_dma_addr = '0; e_dma_data = '0;
        end else begin
            nrd      = m_sel(a) ? m_word(a) : 32'h0;
            snoop_ok = (m_phase == PH_IDLE);
            e_dma_wr = 0;
            case (m_phase)
                PH_IDLE: if (load_done && m_pending) begin m_phase = PH_WAIT; e_halt = 1; end
                PH_WAIT: if (halt_ack) begin m_phase = PH_COPY; m_pos = 0; end
                PH_COPY: begin
                    e_dma_wr   = 1;
                    e_dma_addr = CSTART + 16'(m_pos);
                    e_dma_data = m_sh[m_pos];
                    m_pos++;
                    if (m_pos == int'(HS_BYTES)) m_phase = PH_FIN;
                end
                default: begin e_halt = 0; m_pending = 0; m_phase = PH_IDLE; end
            endcase
            wb = -1;
            if (bus.bridge_wr && m_sel(a)) begin
                wb = int'((a - BASE) >> 2);
                for (int j = 0; j < 4; j++) m_sh[wb*4+j] = bus.bridge_wr_data[31-8*j -: 8];
                m_pending = 1;
            end
            cb  = int'(cpu_addr) - int'(CSTART);
            set = 0;
            if (cpu_wr && snoop_ok && cb >= 0 && cb < int'(HS_BYTES) && (cb / 4) != wb) begin
                if (m_sh[cb] != cpu_wr_data) set = 1;
                m_sh[cb] = cpu_wr_data;
            end
            if (set)               m_dirty = 1;
            else if (hs_dirty_clr) m_dirty = 0;
            e_rd = nrd;
        end
    end

    always @(negedge clk_74a) begin
        if (cmp_en) begin
            check("hs_selected", 32'(bus.hs_selected), 32'(m_sel(bus.bridge_addr)));
            check("hs_rd_data", bus.hs_rd_data, e_rd);
            check("halt_req", 32'(halt_req), 32'(e_halt));
            check("dma_wr", 32'(dma_wr), 32'(e_dma_wr));
            check("hs_dirty", 32'(hs_dirty), 32'(m_dirty));
            if (e_dma_wr) begin
                check("dma_addr", 32'(dma_addr), 32'(e_dma_addr));
                check("dma_data", 32'(dma_data), 32'(e_dma_data));
            end
        end
    end

    task automatic bridge_write(input logic [31:0] a, input logic [31:0] d);
        bus.bridge_addr = a; bus.bridge_wr_data = d; bus.bridge_wr = 1'b1;
        step();
        bus.bridge_wr = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_wr_data = d; cpu_wr = 1'b1;
        step();
        cpu_wr = 1'b0;
    endtask

    task automatic pulse_load();
        load_done = 1'b1;
        step();
        load_done = 1'b0;
    endtask

    initial begin
        int          cnt, first, last, guard, quiet;
        bit          contig, addr_ok;
        logic [7:0]  got [HS_BYTES];
        int          pick;

        reset = 1'b1; load_done = 1'b0; cpu_wr = 1'b0; halt_ack = 1'b0; hs_dirty_clr = 1'b0;
        cpu_addr = '0; cpu_wr_data = '0;
        bus.bridge_addr = '0; bus.bridge_wr = 1'b0; bus.bridge_wr_data = '0; bus.bridge_rd = 1'b0;
        step();
        cmp_en = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        check("rst_hs_dirty", 32'(hs_dirty), 32'h0);
        check("rst_halt_req", 32'(halt_req), 32'h0);
        check("rst_dma_addr", 32'(dma_addr), 32'h0);
        check("rst_dma_data", 32'(dma_data), 32'h0);

        // Window edges and read latency.
        bus.bridge_addr = 32'h2000_0004; bus.bridge_rd = 1'b1; #1;
        check("sel_inside", 32'(bus.hs_selected), 32'h1);
        step();
        check("rd_after_reset", bus.hs_rd_data, 32'h0);
        bus.bridge_addr = 32'h2000_0040; #1;
        check("sel_upper_edge", 32'(bus.hs_selected), 32'h0);
        bus.bridge_addr = 32'h1FFF_FFFF; #1;
        check("sel_below_base", 32'(bus.hs_selected), 32'h0);
        bus.bridge_rd = 1'b0;

        // load_done without a pending bridge write is ignored.
        pulse_load(); step(); step();
        check("load_no_pending", 32'(halt_req), 32'h0);

        bridge_write(32'h2000_0000, 32'hAABB_CCDD);
        step();
        check("rd_word0", bus.hs_rd_data, 32'hAABB_CCDD);

        cpu_write(16'h5C85, 8'h12);
        bus.bridge_addr = 32'h2000_0004;
        step();
        check("rd_word1_snoop", bus.hs_rd_data, 32'h0012_0000);
        check("dirty_set", 32'(hs_dirty), 32'h1);
        hs_dirty_clr = 1'b1; step(); hs_dirty_clr = 1'b0;
        check("dirty_cleared", 32'(hs_dirty), 32'h0);
        cpu_write(16'h5C85, 8'h12);
        step();
        check("dirty_same_byte", 32'(hs_dirty), 32'h0);

        // Bridge and CPU hit the same word in one cycle: bridge word wins.
        cpu_addr = 16'h5C84; cpu_wr_data = 8'h99; cpu_wr = 1'b1;
        bridge_write(32'h2000_0004, 32'h1122_3344);
        cpu_wr = 1'b0;
        step();
        check("conflict_word", bus.hs_rd_data, 32'h1122_3344);
        check("conflict_dirty", 32'(hs_dirty), 32'h0);

        hs_dirty_clr = 1'b1;
        cpu_write(16'h5C86, 8'h55);
        hs_dirty_clr = 1'b0;
        check("dirty_set_wins", 32'(hs_dirty), 32'h1);

        // Restore: halt, hold off for 10 cycles, then 64 contiguous strobes.
        pulse_load();
        check("halt_req_up", 32'(halt_req), 32'h1);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (dma_wr) cnt++;
        end
        check("no_dma_before_ack", 32'(cnt), 32'h0);
        check("halt_req_held", 32'(halt_req), 32'h1);
        halt_ack = 1'b1;
        cnt = 0; first = -1; last = -1; contig = 1; addr_ok = 1;
        for (int c = 0; c < 200; c++) begin
            step();
            if (dma_wr) begin
                if (first < 0) first = c;
                else if (c != last + 1) contig = 0;
                last = c;
                if (cnt < int'(HS_BYTES)) begin
                    if (dma_addr != CSTART + 16'(cnt)) addr_ok = 0;
                    got[cnt] = dma_data;
                end
                cnt++;
            end
            if (cnt > 0 && !dma_wr && !halt_req) break;
        end
        halt_ack = 1'b0;
        check("dma_count", 32'(cnt), 32'(HS_BYTES));
        check("dma_contiguous", 32'(contig), 32'h1);
        check("dma_addr_seq", 32'(addr_ok), 32'h1);
        check("dma_byte0", 32'(got[0]), 32'hAA);
        check("dma_byte3", 32'(got[3]), 32'hDD);
        check("dma_byte6", 32'(got[6]), 32'h55);
        check("halt_req_released", 32'(halt_req), 32'h0);

        // Reset in the middle of a restore abandons it.
        bridge_write(32'h2000_0008, 32'h0102_0304);
        pulse_load();
        halt_ack = 1'b1;
        guard = 0;
        while (!(dma_wr && dma_addr == CSTART + 16'd20) && guard < 200) begin
            step();
            guard++;
        end
        check("reached_byte20", 32'(guard < 200), 32'h1);
        reset = 1'b1;
        step();
        check("rst_mid_dma_wr", 32'(dma_wr), 32'h0);
        check("rst_mid_halt", 32'(halt_req), 32'h0);
        reset = 1'b0; halt_ack = 1'b0;
        bus.bridge_addr = 32'h2000_0008;
        step();
        check("rst_mid_shadow", bus.hs_rd_data, 32'h0);
        pulse_load(); step();
        halt_ack = 1'b1; quiet = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (dma_wr || halt_req) quiet++;
        end
        halt_ack = 1'b0;
        check("idle_after_reset", 32'(quiet), 32'h0);

        // Randomized traffic checked cycle by cycle against the model.
        for (int c = 0; c < 4000; c++) begin
            pick = int'($urandom_range(0, 3));
            case (pick)
                0: bus.bridge_addr = BASE + 32'($urandom_range(0, HS_BYTES + 8));
                1: bus.bridge_addr = BASE - 32'($urandom_range(1, 8));
                2: bus.bridge_addr = $urandom;
                default: bus.bridge_addr = BASE + 32'($urandom_range(0, HS_BYTES - 1));
            endcase
            bus.bridge_wr      = ($urandom_range(0, 99) < 12);
            bus.bridge_wr_data = $urandom;
            bus.bridge_rd      = $urandom_range(0, 1) == 1;
            cpu_addr           = CSTART - 16'd8 + 16'($urandom_range(0, HS_BYTES + 16));
            cpu_wr             = ($urandom_range(0, 99) < 35);
            cpu_wr_data        = 8'($urandom_range(0, 3));
            hs_dirty_clr       = ($urandom_range(0, 99) < 10);
            load_done          = ($urandom_range(0, 99) < 6);
            halt_ack           = ($urandom_range(0, 99) < 40);
            reset              = ($urandom_range(0, 999) < 2);
            step();
        end
        reset = 1'b0; bus.bridge_wr = 1'b0; cpu_wr = 1'b0; load_done = 1'b0;
        hs_dirty_clr = 1'b0; halt_ack = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
